// File: rtl/ahb_sram64_ctrl_if.sv
// AHB-Lite slave bus plus synchronous SRAM port bundle for ahb_sram64_ctrl.
interface ahb_sram64_ctrl_if #(
  parameter int unsigned AW = 12
);
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [63:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [63:0]   HRDATA;
  logic          sram_en;
  logic [7:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [63:0]   sram_wdata;
  logic [63:0]   sram_rdata;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, sram_rdata,
    output HREADYOUT, HRESP, HRDATA, sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, sram_rdata,
    input  HREADYOUT, HRESP, HRDATA, sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/ahb_sram64_ctrl.sv
// Zero-wait AHB-Lite to single-port 64-bit SRAM bridge with a one-entry
// posted write buffer and byte-lane read merging for coherence.
module ahb_sram64_ctrl #(
  parameter int unsigned AW = 12
) (
  input logic               HCLK,
  input logic               HRESET,
  ahb_sram64_ctrl_if.slave  bus
);

  localparam int unsigned DW = 64;
  localparam int unsigned NB = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic          vt_c, misalign_c, illegal_c, rd_ap_c, wr_ap_c;
  logic [NB-1:0] mask_c;
  logic [AW-1:0] word_c;

  logic          rd_dp_q, rd_dp_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_dp_q, wr_dp_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [NB-1:0] wr_mask_q, wr_mask_d;

  logic          buf_vld_q, buf_vld_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [NB-1:0] buf_mask_q, buf_mask_d;
  logic [DW-1:0] buf_data_q, buf_data_d;

  logic [1:0]    state_q, state_d;

  logic          sram_en_c;
  logic [NB-1:0] sram_we_c;
  logic [AW-1:0] sram_addr_c;
  logic [DW-1:0] sram_wdata_c;
  logic          hit_c;
  logic [DW-1:0] merged_c;
  logic          unused_c;

  // Reset gates the transfer qualifier so the SRAM strobe stays low while held.
  assign vt_c   = bus.HSEL & bus.HTRANS[1] & bus.HREADY & ~HRESET;
  assign word_c = bus.HADDR[AW+2:3];

  always_comb begin
    mask_c     = '0;
    misalign_c = 1'b0;
    case (bus.HSIZE)
      3'd0: mask_c = NB'(1) << bus.HADDR[2:0];
      3'd1: begin
        mask_c     = NB'(3) << {bus.HADDR[2:1], 1'b0};
        misalign_c = bus.HADDR[0];
      end
      3'd2: begin
        mask_c     = NB'(15) << {bus.HADDR[2], 2'b00};
        misalign_c = |bus.HADDR[1:0];
      end
      3'd3: begin
        mask_c     = '1;
        misalign_c = |bus.HADDR[2:0];
      end
      default: misalign_c = 1'b1;
    endcase
  end

  assign illegal_c = vt_c & misalign_c;
  assign rd_ap_c   = vt_c & ~misalign_c & ~bus.HWRITE;
  assign wr_ap_c   = vt_c & ~misalign_c & bus.HWRITE;

  always_comb begin
    rd_dp_d   = rd_ap_c;
    rd_addr_d = rd_ap_c ? word_c : rd_addr_q;
    wr_dp_d   = wr_ap_c;
    wr_addr_d = wr_ap_c ? word_c : wr_addr_q;
    wr_mask_d = wr_ap_c ? mask_c : wr_mask_q;
  end

  // SRAM port arbitration: read address phase wins, then buffer, then direct write.
  always_comb begin
    sram_en_c    = 1'b0;
    sram_we_c    = '0;
    sram_addr_c  = '0;
    sram_wdata_c = '0;
    buf_vld_d    = buf_vld_q;
    buf_addr_d   = buf_addr_q;
    buf_mask_d   = buf_mask_q;
    buf_data_d   = buf_data_q;
    if (rd_ap_c) begin
      sram_en_c   = 1'b1;
      sram_addr_c = word_c;
    end else if (buf_vld_q) begin
      sram_en_c    = 1'b1;
      sram_we_c    = buf_mask_q;
      sram_addr_c  = buf_addr_q;
      sram_wdata_c = buf_data_q;
      buf_vld_d    = 1'b0;
    end else if (wr_dp_q) begin
      sram_en_c    = 1'b1;
      sram_we_c    = wr_mask_q;
      sram_addr_c  = wr_addr_q;
      sram_wdata_c = bus.HWDATA;
    end
    if (wr_dp_q && (rd_ap_c || buf_vld_q)) begin
      buf_vld_d  = 1'b1;
      buf_addr_d = wr_addr_q;
      buf_mask_d = wr_mask_q;
      buf_data_d = bus.HWDATA;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (illegal_c) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = illegal_c ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rd_dp_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_dp_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_mask_q  <= '0;
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_mask_q <= '0;
      buf_data_q <= '0;
      state_q    <= ST_IDLE;
    end else begin
      rd_dp_q    <= rd_dp_d;
      rd_addr_q  <= rd_addr_d;
      wr_dp_q    <= wr_dp_d;
      wr_addr_q  <= wr_addr_d;
      wr_mask_q  <= wr_mask_d;
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_mask_q <= buf_mask_d;
      buf_data_q <= buf_data_d;
      state_q    <= state_d;
    end
  end

  // Merge uses start-of-cycle buffer contents, so a same-cycle commit is harmless.
  assign hit_c = buf_vld_q && (buf_addr_q == rd_addr_q);

  always_comb begin
    merged_c = '0;
    for (int i = 0; i < int'(NB); i++) begin
      merged_c[i*8 +: 8] = (hit_c && buf_mask_q[i]) ? buf_data_q[i*8 +: 8]
                                                    : bus.sram_rdata[i*8 +: 8];
    end
  end

  assign bus.HRDATA     = rd_dp_q ? merged_c : '0;
  assign bus.HREADYOUT  = (state_q != ST_ERR1);
  assign bus.HRESP      = (state_q != ST_IDLE);
  assign bus.sram_en    = sram_en_c;
  assign bus.sram_we    = sram_we_c;
  assign bus.sram_addr  = sram_addr_c;
  assign bus.sram_wdata = sram_wdata_c;

  assign unused_c = ^{bus.HADDR[31:AW+3], bus.HTRANS[0]};

endmodule
